bool_sweep_checker: RTL and testbench

//  Parametrised, self-sequencing exhaustive truth-table checker for a combinational boolean block.

---
 rtl/bool_sweep_checker.sv | 94 +++++++++
 tb/tb_bool_sweep_checker.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bool_sweep_checker.sv
// Exhaustive truth-table sweeper: walks every input vector of a combinational
// block, records the observed output and compares it against a golden table.
module bool_sweep_checker #(
  parameter int N_IN = 4,
  parameter int HOLD = 2,
  parameter logic [(2**N_IN)-1:0] EXPECT = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              f_in,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     mismatch_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec,
  output logic [(2**N_IN)-1:0] tt_out
);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HC_LAST = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_d;
  logic [HW-1:0] hc;
  logic          sample, last, mismatch, go;
  logic [N_IN:0] cnt_next;

  assign sample   = (state == RUN) && (hc == HC_LAST);
  assign last     = &vec_out;
  assign mismatch = f_in != EXPECT[vec_out];
  assign go       = start && (state != RUN);
  assign cnt_next = mismatch_cnt + (N_IN+1)'(mismatch);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: if (start) state_d = RUN;
      RUN:        if (sample && last) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_out        <= '0;
      hc             <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      tt_out         <= '0;
    end else if (go) begin
      vec_out        <= '0;
      hc             <= '0;
      busy           <= 1'b1;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_cnt   <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
      tt_out         <= '0;
    end else if (state == RUN) begin
      if (sample) begin
        tt_out[vec_out] <= f_in;
        mismatch_cnt    <= cnt_next;
        if (mismatch && !fail_valid) begin
          fail_valid     <= 1'b1;
          first_fail_vec <= vec_out;
        end
        if (!last) begin
          vec_out <= vec_out + 1'b1;
          hc      <= '0;
        end else begin
          // terminal vector stays on vec_out after the sweep ends
          busy <= 1'b0;
          done <= 1'b1;
          pass <= (cnt_next == '0);
        end
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_bool_sweep_checker.sv
// Directed bench: 4-input/HOLD=2 checker against AND, stuck-0 and stuck-1 DUTs,
// plus a 2-input/HOLD=1 checker against XOR.
module tb_bool_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int mode = 0;
  logic start4 = 1'b0, start2 = 1'b0;
  logic f4, f2;

  logic [3:0]  vec4, ffv4;
  logic        busy4, done4, pass4, fv4;
  logic [4:0]  cnt4;
  logic [15:0] tt4;

  logic [1:0]  vec2, ffv2;
  logic        busy2, done2, pass2, fv2;
  logic [2:0]  cnt2;
  logic [3:0]  tt2;

  assign f4 = (mode == 0) ? &vec4 : (mode == 1) ? 1'b0 : 1'b1;
  assign f2 = ^vec2;

  bool_sweep_checker #(.N_IN(4), .HOLD(2), .EXPECT(16'h8000)) u4 (
    .clk(clk), .rst(rst), .start(start4), .f_in(f4), .vec_out(vec4),
    .busy(busy4), .done(done4), .pass(pass4), .mismatch_cnt(cnt4),
    .fail_valid(fv4), .first_fail_vec(ffv4), .tt_out(tt4));

  bool_sweep_checker #(.N_IN(2), .HOLD(1), .EXPECT(4'h6)) u2 (
    .clk(clk), .rst(rst), .start(start2), .f_in(f2), .vec_out(vec2),
    .busy(busy2), .done(done2), .pass(pass2), .mismatch_cnt(cnt2),
    .fail_valid(fv2), .first_fail_vec(ffv2), .tt_out(tt2));

  int checks = 0;
  int fails  = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, ".vec"},  32'(vec4), 0);
    chk({tag, ".busy"}, 32'(busy4), 0);
    chk({tag, ".done"}, 32'(done4), 0);
    chk({tag, ".pass"}, 32'(pass4), 0);
    chk({tag, ".cnt"},  32'(cnt4), 0);
    chk({tag, ".fv"},   32'(fv4), 0);
    chk({tag, ".ffv"},  32'(ffv4), 0);
    chk({tag, ".tt"},   32'(tt4), 0);
  endtask

  // pulse start4 for one edge, then count edges until busy drops
  task automatic sweep4(input string tag);
    int n;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk({tag, ".busy_on"}, 32'(busy4), 1);
    chk({tag, ".done_clr"}, 32'(done4), 0);
    n = 0;
    while (busy4 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, ".latency"}, 32'(n), 32);
    chk({tag, ".done"}, 32'(done4), 1);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk_zero4("reset");
    chk("reset.busy2", 32'(busy2), 0);
    chk("reset.tt2", 32'(tt2), 0);

    // AND gate matches golden table
    mode = 0;
    sweep4("and");
    chk("and.pass", 32'(pass4), 1);
    chk("and.cnt", 32'(cnt4), 0);
    chk("and.fv", 32'(fv4), 0);
    chk("and.tt", 32'(tt4), 32'h8000);
    chk("and.vec_hold", 32'(vec4), 4'hF);

    // stuck-at-0: only vector 15 differs
    mode = 1;
    sweep4("s0");
    chk("s0.cnt", 32'(cnt4), 1);
    chk("s0.fv", 32'(fv4), 1);
    chk("s0.ffv", 32'(ffv4), 4'hF);
    chk("s0.pass", 32'(pass4), 0);
    chk("s0.tt", 32'(tt4), 0);

    // stuck-at-1: 15 mismatches, first at vector 0
    mode = 2;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("s1.clr_cnt", 32'(cnt4), 0);
    chk("s1.clr_fv", 32'(fv4), 0);
    chk("s1.clr_tt", 32'(tt4), 0);
    n = 0;
    while (busy4 && n < 100) begin tick(); n++; end
    chk("s1.latency", 32'(n), 32);
    chk("s1.cnt", 32'(cnt4), 15);
    chk("s1.ffv", 32'(ffv4), 0);
    chk("s1.tt", 32'(tt4), 32'hFFFF);
    chk("s1.pass", 32'(pass4), 0);

    // start during RUN is ignored
    mode = 0;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("ign.vec0", 32'(vec4), 0);
    tick();
    chk("ign.vec0_hold", 32'(vec4), 0);
    tick();
    chk("ign.vec1", 32'(vec4), 1);
    for (int i = 0; i < 8; i++) tick();
    chk("ign.vec5", 32'(vec4), 5);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("ign.vec5_kept", 32'(vec4), 5);
    n = 11;
    while (busy4 && n < 100) begin tick(); n++; end
    chk("ign.latency", 32'(n), 32);
    chk("ign.pass", 32'(pass4), 1);

    // reset mid-sweep aborts, then a clean sweep
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int i = 0; i < 18; i++) tick();
    chk("abort.vec9", 32'(vec4), 9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_zero4("abort");
    tick();
    chk("abort.idle", 32'(busy4), 0);
    sweep4("clean");
    chk("clean.pass", 32'(pass4), 1);
    chk("clean.tt", 32'(tt4), 32'h8000);

    // 2-input XOR, HOLD=1
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("xor.busy_on", 32'(busy2), 1);
    n = 0;
    while (busy2 && n < 100) begin tick(); n++; end
    chk("xor.latency", 32'(n), 4);
    chk("xor.done", 32'(done2), 1);
    chk("xor.pass", 32'(pass2), 1);
    chk("xor.tt", 32'(tt2), 4'h6);
    chk("xor.cnt", 32'(cnt2), 0);
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    chk("xor.rs_done", 32'(done2), 0);
    chk("xor.rs_pass", 32'(pass2), 0);
    chk("xor.rs_tt", 32'(tt2), 0);
    chk("xor.rs_busy", 32'(busy2), 1);
    chk("xor.rs_vec", 32'(vec2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
